// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit: md_op codes, default latencies and FSM states.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MADD  = 3'b100;
    localparam logic [2:0] MD_MADDU = 3'b101;
    localparam logic [2:0] MD_MSUB  = 3'b110;
    localparam logic [2:0] MD_MSUBU = 3'b111;

    localparam int unsigned MD_MULT_CYCLES = 5;
    localparam int unsigned MD_DIV_CYCLES  = 10;

    typedef enum logic {
        StIdle,
        StRun
    } md_state_e;

endpackage

// File: rtl/md_compute.sv
// Combinational 64-bit result for every md_op; accumulate ops exist only with MD_MADD_EN.
module md_compute
    import md_pkg::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result,
    output logic        div0
);

    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        divisor;
    logic [31:0]        quo_u;
    logic [31:0]        rem_u;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic               is_div;
    logic               overflow;

    // Low 64 bits of the sign-extended product equal the signed 32x32 product.
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'b0, A} * {32'b0, B};

    assign is_div   = (md_op == MD_DIV) || (md_op == MD_DIVU);
    assign div0     = is_div && (B == 32'b0);
    assign overflow = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

    // Dividing by 1 yields quotient 0x80000000 / remainder 0 for the overflow case
    // and keeps the divider defined for B == 0 (that result is discarded anyway).
    assign divisor = (div0 || B == 32'b0 || overflow) ? 32'd1 : B;
    assign quo_s   = $signed(A) / $signed(divisor);
    assign rem_s   = $signed(A) % $signed(divisor);
    assign quo_u   = A / divisor;
    assign rem_u   = A % divisor;

    always_comb begin
        result = 64'b0;
        case (md_op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV:   result = {rem_s, quo_s};
            MD_DIVU:  result = {rem_u, quo_u};
`ifdef MD_MADD_EN
            MD_MADD:  result = {hi, lo} + prod_s;
            MD_MADDU: result = {hi, lo} + prod_u;
            MD_MSUB:  result = {hi, lo} - prod_s;
            MD_MSUBU: result = {hi, lo} - prod_u;
`endif
            default:  result = 64'b0;
        endcase
    end

`ifdef MD_MADD_EN
`else
    logic unused_acc;
    assign unused_acc = ^{hi, lo};
`endif

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO owner with fixed-latency multiply/divide; madd/msub family enabled by MD_MADD_EN.
module mult_div_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        hiWE,
    input  logic        loWE,
    input  logic        mdsel,
    output logic        busy,
    output logic [31:0] md_out
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    md_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic [31:0]     pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic            pend_div0_q, pend_div0_d;
    logic [63:0]     result;
    logic            div0;
    logic            op_valid;
    logic            is_div;

    md_compute u_md_compute (
        .md_op  (md_op),
        .A      (A),
        .B      (B),
        .hi     (hi_q),
        .lo     (lo_q),
        .result (result),
        .div0   (div0)
    );

`ifdef MD_MADD_EN
    assign op_valid = 1'b1;
`else
    assign op_valid = ~md_op[2];
`endif

    assign is_div = (md_op[2:1] == 2'b01);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        pend_hi_d   = pend_hi_q;
        pend_lo_d   = pend_lo_q;
        pend_div0_d = pend_div0_q;
        unique case (state_q)
            StIdle: begin
                if (start && op_valid) begin
                    pend_hi_d   = result[63:32];
                    pend_lo_d   = result[31:0];
                    pend_div0_d = div0;
                    cnt_d       = is_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
                    state_d     = StRun;
                end else if (!start) begin
                    if (hiWE) hi_d = A;
                    if (loWE) lo_d = A;
                end
            end
            StRun: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q <= CntW'(1)) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    if (!pend_div0_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            pend_hi_q   <= '0;
            pend_lo_q   <= '0;
            pend_div0_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            pend_hi_q   <= pend_hi_d;
            pend_lo_q   <= pend_lo_d;
            pend_div0_q <= pend_div0_d;
        end
    end

    assign busy   = (state_q == StRun);
    assign md_out = mdsel ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: random ops/writes checked against an arithmetic model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset, start, hiWE, loWE, mdsel, settle;
    logic [2:0]  md_op;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] md_out;

    logic [63:0] exp_q[$];
    logic [31:0] mh, ml;
    int          nchk = 0;
    int          nerr = 0;

    mult_div_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .A      (A),
        .B      (B),
        .hiWE   (hiWE),
        .loWE   (loWE),
        .mdsel  (mdsel),
        .busy   (busy),
        .md_out (md_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on 64-bit values.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output bit valid, output bit commit, output logic [63:0] res,
                         output int lat);
        longint          sp;
        longint unsigned up;
        int              ia, ib;
        ia = int'(a);
        ib = int'(b);
        sp = longint'(ia) * longint'(ib);
        up = 64'(a) * 64'(b);
        valid  = 1'b1;
        commit = 1'b1;
        lat    = 5;
        res    = 64'b0;
        case (op)
            3'd0: res = sp;
            3'd1: res = up;
            3'd2, 3'd3: begin
                lat = 10;
                if (b == 32'b0) commit = 1'b0;
                else if (op == 3'd3) res = {a % b, a / b};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
                else res = {32'(ia % ib), 32'(ia / ib)};
            end
            default: begin
`ifdef MD_MADD_EN
                case (op)
                    3'd4:    res = {mh, ml} + sp;
                    3'd5:    res = {mh, ml} + up;
                    3'd6:    res = {mh, ml} - sp;
                    default: res = {mh, ml} - up;
                endcase
`else
                valid  = 1'b0;
                commit = 1'b0;
`endif
            end
        endcase
    endtask

    task automatic expect_settled();
        exp_q.push_back({mh, ml});
        settle = 1'b1;
        @(posedge clk);
        #1 settle = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        start = 1'b0;
        hiWE  = 1'b0;
        loWE  = 1'b0;
        exp_q.delete();
        mh = 32'b0;
        ml = 32'b0;
        @(posedge clk);
        #1 check("reset_busy", {31'b0, busy}, 32'b0);
        expect_settled();
        reset = 1'b1;
    endtask

    task automatic write_hl(input bit wh, input bit wl, input logic [31:0] val);
        hiWE = wh;
        loWE = wl;
        A    = val;
        @(posedge clk);
        #1 hiWE = 1'b0;
        loWE = 1'b0;
        if (wh) mh = val;
        if (wl) ml = val;
        expect_settled();
    endtask

    // poke: busy cycle at which an mthi is attempted; rst_at: busy cycle at which reset hits.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int poke, input int rst_at);
        bit          valid, commit;
        logic [63:0] res;
        int          lat, n;
        model(op, a, b, valid, commit, res, lat);
        start = 1'b1;
        md_op = op;
        A     = a;
        B     = b;
        @(posedge clk);
        #1 start = 1'b0;
        if (!valid) begin
            check("ignored_op_busy", {31'b0, busy}, 32'b0);
            return;
        end
        if (commit) begin
            mh = res[63:32];
            ml = res[31:0];
        end
        exp_q.push_back({mh, ml});
        n = 0;
        while (busy && n < 200) begin
            n++;
            hiWE = (n == poke);
            A    = (n == poke) ? 32'h0000_DEAD : a;
            if (n == rst_at) begin
                reset = 1'b0;
                exp_q.delete();
                mh = 32'b0;
                ml = 32'b0;
                #1 check("reset_mid_busy", {31'b0, busy}, 32'b0);
                expect_settled();
                reset = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
        end
        hiWE = 1'b0;
        check("busy_len", 32'(n), 32'(lat));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: compares HI and LO whenever a result commits or the stimulus flags a settle.
    initial begin
        logic        busy_prev;
        logic [63:0] e;
        busy_prev = 1'b0;
        mdsel     = 1'b0;
        forever begin
            @(negedge clk);
            if (settle || (busy_prev && !busy && reset)) begin
                if (exp_q.size() == 0) begin
                    nchk++;
                    nerr++;
                    $display("FAIL unexpected_output: md_out 0x%08h, expected no output", md_out);
                end else begin
                    e     = exp_q.pop_front();
                    mdsel = 1'b1;
                    #1 check("hi", md_out, e[63:32]);
                    mdsel = 1'b0;
                    #1 check("lo", md_out, e[31:0]);
                end
            end
            busy_prev = busy;
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        settle = 1'b0;
        reset  = 1'b0;
        start  = 1'b0;
        hiWE   = 1'b0;
        loWE   = 1'b0;
        md_op  = 3'b0;
        A      = 32'b0;
        B      = 32'b0;
        mh     = 32'b0;
        ml     = 32'b0;
        @(posedge clk);
        #1 do_reset();

        issue(3'd0, 32'hFFFF_FFFF, 32'd2, 0, 0);
        issue(3'd1, 32'hFFFF_FFFF, 32'd2, 0, 0);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        do_reset();
        write_hl(1'b0, 1'b1, 32'h0000_1234);
        issue(3'd3, 32'd7, 32'd0, 0, 0);
        issue(3'd2, 32'd9, 32'd0, 0, 0);
        issue(3'd0, 32'd3, 32'd5, 2, 0);
        issue(3'd2, 32'd100, 32'd7, 0, 3);
        write_hl(1'b1, 1'b1, 32'hCAFE_F00D);
        issue(3'd4, 32'd11, 32'd13, 0, 0);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) < 2) begin
                write_hl(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            end else begin
                issue(3'($urandom_range(0, 7)), pick(), pick(), 0, 0);
            end
        end

        repeat (3) @(posedge clk);
        #1 check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
